// File: rtl/inst_mem_loader_if.sv
// Byte stream in, word write port out, for the instruction memory loader.
// master: loader side; slave: host/memory side.
interface inst_mem_loader_if;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_adr;
    logic [31:0] wr_data;

    modport master (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output wr_en,
        output wr_adr,
        output wr_data
    );

    modport slave (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  wr_en,
        input  wr_adr,
        input  wr_data
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Packs a byte stream big-endian into words and writes them to instruction memory.
// Optional: define LOADER_CHECKSUM_EN to add a running word checksum output.
module inst_mem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [31:0]          i_base_adr,
    input  logic [CNT_W-1:0]     i_num_words,
    inst_mem_loader_if.master    bus,
    output logic                 o_cpu_stall,
    output logic                 o_done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]          o_checksum,
`endif
    output logic [CNT_W-1:0]     o_words_written
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0]      ADR_MASK = 32'(MEM_BYTES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           r_state, w_state;
    logic [31:0]      r_adr, w_adr;
    logic [CNT_W-1:0] r_remaining, w_remaining;
    logic [1:0]       r_idx, w_idx;
    logic [31:0]      r_shreg, w_shreg;
    logic             r_in_ready, w_in_ready;
    logic             r_wr_en, w_wr_en;
    logic [31:0]      r_wr_adr, w_wr_adr;
    logic [31:0]      r_wr_data, w_wr_data;
    logic             r_stall, w_stall;
    logic             r_done, w_done;
    logic [CNT_W-1:0] r_words, w_words;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]      r_checksum, w_checksum;
`endif

    // State and registered outputs; async reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_adr       <= '0;
            r_remaining <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_in_ready  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_adr    <= '0;
            r_wr_data   <= '0;
            r_stall     <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_adr       <= w_adr;
            r_remaining <= w_remaining;
            r_idx       <= w_idx;
            r_shreg     <= w_shreg;
            r_in_ready  <= w_in_ready;
            r_wr_en     <= w_wr_en;
            r_wr_adr    <= w_wr_adr;
            r_wr_data   <= w_wr_data;
            r_stall     <= w_stall;
            r_done      <= w_done;
            r_words     <= w_words;
`ifdef LOADER_CHECKSUM_EN
            r_checksum  <= w_checksum;
`endif
        end
    end

    // Next state; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        w_state     = r_state;
        w_adr       = r_adr;
        w_remaining = r_remaining;
        w_idx       = r_idx;
        w_shreg     = r_shreg;
        w_wr_adr    = r_wr_adr;
        w_wr_data   = r_wr_data;
        w_words     = r_words;
`ifdef LOADER_CHECKSUM_EN
        w_checksum  = r_checksum;
`endif
        unique case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_adr       = {i_base_adr[31:2], 2'b00};
                    w_remaining = i_num_words;
                    w_idx       = 2'd0;
                    w_words     = '0;
`ifdef LOADER_CHECKSUM_EN
                    w_checksum  = '0;
`endif
                    w_state     = (i_num_words == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.in_valid) begin
                    w_shreg = {r_shreg[23:0], bus.in_byte};
                    w_idx   = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state   = WRITE;
                        w_wr_adr  = r_adr;
                        w_wr_data = {r_shreg[23:0], bus.in_byte};
                    end
                end
            end
            WRITE: begin
                w_adr       = (r_adr + 32'd4) & ADR_MASK;
                w_words     = r_words + ONE;
                w_remaining = r_remaining - ONE;
`ifdef LOADER_CHECKSUM_EN
                w_checksum  = r_checksum + r_wr_data;
`endif
                w_state     = (r_remaining == ONE) ? DONE : COLLECT;
            end
            default: w_state = IDLE;
        endcase
        w_in_ready = (w_state == COLLECT);
        w_wr_en    = (w_state == WRITE);
        w_stall    = (w_state == COLLECT) || (w_state == WRITE);
        w_done     = (w_state == DONE);
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.wr_en        = r_wr_en;
    assign bus.wr_adr       = r_wr_adr;
    assign bus.wr_data      = r_wr_data;
    assign o_cpu_stall      = r_stall;
    assign o_done           = r_done;
    assign o_words_written  = r_words;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum       = r_checksum;
`endif

endmodule
